// File: rtl/acc_94bit_deskew.sv
// acc_94bit_deskew: sums groups of NTERMS 94-bit terms delivered by a skewed
// upstream adder (low 47 bits in the acceptance cycle, high 47 bits one cycle
// later). Each completed group sum is presented on a valid/ready output.
// Optional feature macro: ACC94_OVF_DETECT_EN adds the out_ovf port with a
// sticky per-group carry-out-of-ACC_W flag.
module acc_94bit_deskew #(
    parameter int NTERMS = 8,
    parameter int GUARD  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [46:0]       c_low,
    input  logic [46:0]       c_high,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [93+GUARD:0] out_sum
`ifdef ACC94_OVF_DETECT_EN
    ,
    output logic              out_ovf
`endif
);

    localparam int ACC_W = 94 + GUARD;
    localparam int CNT_W = $clog2(NTERMS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NTERMS - 1);

    logic [46:0]      r_c_low;
    logic             r_inflight;
    logic [CNT_W-1:0] r_cnt;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_out_sum;
    logic             r_out_valid;

    logic             w_accept;
    logic             w_last;
    logic [93:0]      w_term;
    logic [ACC_W-1:0] w_sum;

    // Ready depends only on the output slot: free, or being drained this cycle.
    assign in_ready  = !r_out_valid || out_ready;
    assign w_accept  = in_valid && in_ready;
    // High half arrives one cycle after the low half; pair it with the
    // registered low half, independent of whatever in_valid does now.
    assign w_term    = {c_high, r_c_low};
    assign w_last    = (r_cnt == LAST);
    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;

`ifdef ACC94_OVF_DETECT_EN
    logic w_carry;
    assign {w_carry, w_sum} = {1'b0, r_acc} + (ACC_W + 1)'(w_term);
`else
    assign w_sum = r_acc + ACC_W'(w_term);
`endif

    // Capture the low half and mark a term in flight for the next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_c_low    <= '0;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= w_accept;
            if (w_accept) begin
                r_c_low <= c_low;
            end
        end
    end

    // Accumulate in-flight terms; on the last term of a group publish the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_acc       <= '0;
            r_out_sum   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            if (r_inflight) begin
                if (w_last) begin
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_out_sum <= w_sum;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_sum;
                end
            end
            // A completion on the same edge as a drain keeps valid high.
            if (r_inflight && w_last) begin
                r_out_valid <= 1'b1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

`ifdef ACC94_OVF_DETECT_EN
    logic r_ovf_sticky;
    logic r_out_ovf;
    logic w_ovf_grp;

    // Sticky flag restarts at the first term of each group.
    assign w_ovf_grp = ((r_cnt == '0) ? 1'b0 : r_ovf_sticky) | w_carry;
    assign out_ovf   = r_out_ovf;

    // Track carries out of ACC_W across the group; publish with the sum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_sticky <= 1'b0;
            r_out_ovf    <= 1'b0;
        end else if (r_inflight) begin
            if (w_last) begin
                r_out_ovf    <= w_ovf_grp;
                r_ovf_sticky <= 1'b0;
            end else begin
                r_ovf_sticky <= w_ovf_grp;
            end
        end
    end
`endif

endmodule

// File: tb/tb_acc_94bit_deskew.sv
// Testbench for acc_94bit_deskew. Two instances share all inputs: u_dut
// (NTERMS=4, GUARD=4) and u_wrap (NTERMS=4, GUARD=1) whose 95-bit sum wraps.
// With ACC94_OVF_DETECT_EN defined, out_ovf of both is checked as well.
module tb_acc_94bit_deskew;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [46:0] c_low;
    logic [46:0] c_high;
    logic        out_ready;

    logic        in_ready1, out_valid1;
    logic [97:0] out_sum1;
    logic        in_ready2, out_valid2;
    logic [94:0] out_sum2;
`ifdef ACC94_OVF_DETECT_EN
    logic        out_ovf1, out_ovf2;
`endif

    always #5 clk = ~clk;

    acc_94bit_deskew #(.NTERMS(4), .GUARD(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .c_low(c_low), .c_high(c_high), .out_valid(out_valid1),
        .out_ready(out_ready), .out_sum(out_sum1)
`ifdef ACC94_OVF_DETECT_EN
        , .out_ovf(out_ovf1)
`endif
    );

    acc_94bit_deskew #(.NTERMS(4), .GUARD(1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
        .c_low(c_low), .c_high(c_high), .out_valid(out_valid2),
        .out_ready(out_ready), .out_sum(out_sum2)
`ifdef ACC94_OVF_DETECT_EN
        , .out_ovf(out_ovf2)
`endif
    );

    typedef struct {
        logic [46:0] lo [4];
        logic [46:0] hi [4];
        logic [97:0] exp;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;
    int rdy_drops = 0;
    bit rdy_chk = 0;

    logic [46:0] g_lo [16];
    logic [46:0] g_hi [16];
    logic [97:0] exp_q [$];
    logic [97:0] q1 [$];
    logic [97:0] q2 [$];
    logic        q1o [$];
    logic        q2o [$];

    task automatic chk(input string name, input logic [97:0] act, input logic [97:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Record every handshake on the output side of both instances.
    always @(negedge clk) begin
        #1;
        if (out_valid1 && out_ready) begin
            q1.push_back(out_sum1);
`ifdef ACC94_OVF_DETECT_EN
            q1o.push_back(out_ovf1);
`endif
        end
        if (out_valid2 && out_ready) begin
            q2.push_back({3'b000, out_sum2});
`ifdef ACC94_OVF_DETECT_EN
            q2o.push_back(out_ovf2);
`endif
        end
        if (rdy_chk && !in_ready1) rdy_drops++;
    end

    // Back-to-back terms from g_lo/g_hi; each high half trails its low half.
    task automatic send_n(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            c_low    = g_lo[k];
            c_high   = (k == 0) ? 47'h55 : g_hi[k-1];
        end
        @(negedge clk);
        in_valid = 1'b0;
        c_low    = '0;
        c_high   = g_hi[n-1];
        @(negedge clk);
        c_high   = 47'h55;
    endtask

    task automatic fill(input int n, input logic [46:0] lo, input logic [46:0] hi);
        for (int k = 0; k < n; k++) begin
            g_lo[k] = lo;
            g_hi[k] = hi;
        end
    endtask

    task automatic check_q(input string name);
        chk({name, " count"}, 98'(q1.size()), 98'(exp_q.size()));
        chk({name, " wrap count"}, 98'(q2.size()), 98'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            logic [97:0] e;
            e = exp_q[i];
            if (i < q1.size()) chk({name, " sum"}, q1[i], e);
            if (i < q2.size()) chk({name, " wrap sum"}, q2[i], {3'b000, e[94:0]});
`ifdef ACC94_OVF_DETECT_EN
            if (i < q1o.size()) chk({name, " ovf"}, 98'(q1o[i]), 98'(0));
            if (i < q2o.size()) chk({name, " wrap ovf"}, 98'(q2o[i]), 98'(|e[97:95]));
`endif
        end
        exp_q.delete(); q1.delete(); q2.delete(); q1o.delete(); q2o.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        for (int k = 0; k < 4; k++) begin
            vecs[0].lo[k] = 47'd1;                vecs[0].hi[k] = '0;
            vecs[1].lo[k] = (k == 0) ? 47'h7FFF_FFFF_FFFF : '0;
            vecs[1].hi[k] = (k == 0) ? 47'd1 : '0;
            vecs[2].lo[k] = 47'h7FFF_FFFF_FFFF;   vecs[2].hi[k] = 47'h7FFF_FFFF_FFFF;
            vecs[3].lo[k] = 47'(10 * (k + 1));    vecs[3].hi[k] = 47'(k + 1);
            vecs[4].lo[k] = '0;                   vecs[4].hi[k] = 47'h4000_0000_0000;
        end
        vecs[0].exp = 98'd4;
        vecs[1].exp = 98'hFFFF_FFFF_FFFF;
        vecs[2].exp = (98'd1 << 96) - 98'd4;
        vecs[3].exp = (98'd10 << 47) + 98'd100;
        vecs[4].exp = (98'd1 << 95);

        rst_n = 1'b0; in_valid = 1'b0; c_low = '0; c_high = '0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", 98'(out_valid1), 98'(0));
        chk("reset out_sum", out_sum1, '0);
        chk("reset in_ready", 98'(in_ready1), 98'(1));
        chk("reset wrap out_sum", {3'b000, out_sum2}, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Latency: valid appears two cycles after the fourth acceptance.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b1; c_low = 47'd1; c_high = (k == 0) ? 47'h55 : '0;
        end
        @(negedge clk);
        in_valid = 1'b0; c_low = '0; c_high = '0;
        #1 chk("latency +1 out_valid", 98'(out_valid1), 98'(0));
        @(negedge clk);
        #1 chk("latency +2 out_valid", 98'(out_valid1), 98'(1));
        chk("latency +2 out_sum", out_sum1, 98'd4);
        repeat (2) @(negedge clk);
        exp_q.push_back(98'd4);
        check_q("latency");

        for (int v = 0; v < 5; v++) begin
            for (int k = 0; k < 4; k++) begin
                g_lo[k] = vecs[v].lo[k];
                g_hi[k] = vecs[v].hi[k];
            end
            send_n(4);
            repeat (2) @(negedge clk);
            exp_q.push_back(vecs[v].exp);
            check_q($sformatf("vec%0d", v));
        end

        // Continuous stream of three groups with no bubble.
        for (int k = 0; k < 4; k++) begin
            g_lo[k]     = vecs[0].lo[k]; g_hi[k]     = vecs[0].hi[k];
            g_lo[k + 4] = vecs[3].lo[k]; g_hi[k + 4] = vecs[3].hi[k];
            g_lo[k + 8] = vecs[4].lo[k]; g_hi[k + 8] = vecs[4].hi[k];
        end
        rdy_drops = 0;
        rdy_chk = 1'b1;
        send_n(12);
        repeat (2) @(negedge clk);
        rdy_chk = 1'b0;
        chk("stream in_ready drops", 98'(rdy_drops), 98'(0));
        exp_q.push_back(vecs[0].exp);
        exp_q.push_back(vecs[3].exp);
        exp_q.push_back(vecs[4].exp);
        check_q("stream");

        // Back-pressure: held result blocks input; offered terms are ignored.
        out_ready = 1'b0;
        fill(4, 47'd2, '0);
        send_n(4);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            in_valid = 1'b1; c_low = 47'd100; c_high = '0;
            #1;
            chk("bp in_ready", 98'(in_ready1), 98'(0));
            chk("bp out_valid", 98'(out_valid1), 98'(1));
            chk("bp out_sum", out_sum1, 98'd8);
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        #1 chk("bp release in_ready", 98'(in_ready1), 98'(1));
        fill(4, 47'd5, '0);
        send_n(4);
        repeat (2) @(negedge clk);
        exp_q.push_back(98'd8);
        exp_q.push_back(98'd20);
        check_q("backpressure");

        // Reset after two of four terms discards the partial group.
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            in_valid = 1'b1; c_low = 47'd7; c_high = (k == 0) ? 47'h55 : '0;
        end
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk("midreset out_valid", 98'(out_valid1), 98'(0));
        chk("midreset out_sum", out_sum1, '0);
        chk("midreset in_ready", 98'(in_ready1), 98'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fill(4, 47'd3, '0);
        send_n(4);
        repeat (2) @(negedge clk);
        exp_q.push_back(98'd12);
        check_q("reset mid-group");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
